ring_write_scheduler: RTL and testbench
=======================================

Name: ring_write_scheduler

Overview:
- Command sequencer for the FIFO-to-AXI burst writer. Carves a continuous FIFO stream into chunk transfers that land in a circular buffer in memory.
- Drives the writer's BASE_ADDR/TRANSFER_LEN/START and waits for DONE before issuing the next chunk.
- Tracks the ring write pointer and wrap bit, and splits chunks at the ring end.
- Throttles against a software read pointer so unread data is never overwritten. Sits between the CSR block and the burst writer.

Parameters:
- ADDR_W, 32, AXI address width; matches the writer's AXI_ADDR_WIDTH.
- LEN_W, 32, writer TRANSFER_LEN width.
- PTR_W, 20, ring offset width in words (max ring 2^PTR_W-1 words).
- BYTES_PER_WORD, 4, bytes per FIFO/AXI word; must be a power of two.
- CNT_W, 12, FIFO occupancy input width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- cfg_enable  in  1  level; rising edge latches config and starts scheduling
- cfg_ring_base  in  ADDR_W  ring byte base address, word aligned
- cfg_ring_size  in  PTR_W  ring size in words, ≥1
- cfg_chunk_len  in  PTR_W  nominal words per chunk, ≥1
- flush  in  1  pulse; drain residual FIFO words below chunk_len
- fifo_count  in  CNT_W  current FIFO occupancy in words
- rd_ptr  in  PTR_W  consumer read offset in words
- rd_wrap  in  1  consumer wrap bit
- wr_base_addr  out  ADDR_W  to writer BASE_ADDR
- wr_len  out  LEN_W  to writer TRANSFER_LEN
- wr_start  out  1  to writer START; one-cycle pulse
- wr_busy  in  1  from writer BUSY
- wr_done  in  1  from writer DONE pulse
- wr_ptr  out  PTR_W  committed write offset in words
- wr_wrap  out  1  committed wrap bit
- chunk_irq  out  1  one-cycle pulse per completed chunk
- flush_done  out  1  one-cycle pulse when a flush completes
- active  out  1  scheduler not in IDLE
- stalled_full  out  1  level; data waiting but ring full

Behaviour:
- Reset: all outputs 0; all pointers 0; state IDLE.
- States: IDLE, CALC, ISSUE, WAIT_BUSY, WAIT_DONE, COMMIT.
- IDLE → CALC on a rising edge of cfg_enable.
  - On that edge: latch base, size and chunk_len; clear wr_ptr and wr_wrap.
- Fill level:
  - fill = (wr_wrap==rd_wrap) ? wr_ptr−rd_ptr : size−rd_ptr+wr_ptr.
  - free = size−fill.
  - to_end = size−wr_ptr.
- CALC, computed in PTR_W+1-bit arithmetic:
  - len = min(chunk_len, to_end, free).
  - Issue when len≥1 and fifo_count ≥ len → ISSUE.
  - Also issue when a flush is pending and fifo_count≥1, with len = min(len, fifo_count).
  - If free==0 and fifo_count>0: assert stalled_full and stay in CALC.
  - If cfg_enable is low and no flush is pending → IDLE.
- ISSUE:
  - wr_base_addr = base + wr_ptr*BYTES_PER_WORD.
  - wr_len = len, zero-extended.
  - Both outputs are registered and held stable until COMMIT.
  - wr_start=1 for exactly this cycle → WAIT_BUSY.
- WAIT_BUSY: → WAIT_DONE when wr_busy=1.
  - If wr_done is seen first, go directly to COMMIT.
- WAIT_DONE: → COMMIT on wr_done.
  - No timeout; the writer is trusted.
- COMMIT:
  - wr_ptr += len; if the result == size, set wr_ptr=0 and toggle wr_wrap.
  - chunk_irq=1.
  - If a flush is pending and fifo_count − len == 0: clear the flush, pulse flush_done.
  - → CALC.
- Flush:
  - A flush pulse in any state sets flush_pending.
  - A flush with fifo_count==0 at CALC completes immediately with flush_done and no transfer.
  - A flush arriving in IDLE completes in 1 cycle with flush_done.
- cfg_enable deassert mid-transfer: the current chunk completes and commits, then → IDLE. Latched config is ignored until the next rising edge.
- rd_ptr/rd_wrap are sampled combinationally in CALC only. A rd_ptr inconsistent with wr_ptr (fill>size) is treated as free=0.
- At most one outstanding writer command; wr_start is never asserted while wr_busy=1.
- Asynchronous reset mid-operation: all state is cleared. The writer shares the same reset; no recovery is required.

Decomposition:
- Package ring_sched_pkg:
  - state enum (3 bits);
  - function ring_fill(wr_ptr, wr_wrap, rd_ptr, rd_wrap, size);
  - BYTES_PER_WORD-derived shift constant.
- Sub-module ring_ptr_calc: combinational fill, free, to_end and len computation. Keeps the FSM file small and is unit-testable.

Test Plan:
- Config base=0x1000, size=40, chunk=16; fifo_count=64; consumer tracks writes (rd_ptr follows):
  - commands (0x1000,16), (0x1040,16), (0x1080,8);
  - then wr_ptr=0, wr_wrap=1;
  - next command (0x1000,16).
- Same config, rd_ptr=0, rd_wrap=0 frozen:
  - after 40 words, stalled_full=1 and no wr_start;
  - setting rd_ptr=16 → next command (0x1000,16).
- fifo_count=5, chunk=16: no command is issued.
  - Pulse flush → command (base+wr_ptr*4, 5), then flush_done one cycle after the chunk_irq commit.
- Deassert cfg_enable while in WAIT_DONE: DONE still commits wr_ptr+=16 and chunk_irq fires, then IDLE; no further wr_start.
- Writer returns DONE the cycle after START with BUSY never seen: COMMIT still occurs, with wr_start count equal to chunk_irq count.
- Assert ARESETn low during WAIT_DONE:
  - all outputs 0 immediately (asynchronous);
  - after release, re-enable restarts at base with wr_ptr=0.

Source files
------------

// File: rtl/ring_sched_pkg.sv
// Shared types and helpers for the ring write scheduler: FSM encoding,
// ring fill-level arithmetic and byte/word address scaling.
package ring_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_COMMIT    = 3'd5
  } state_e;

  // Widest ring offset the fill helper handles; callers zero-extend into it.
  localparam int RING_W = 32;

  function automatic int word_shift(input int bytes_per_word);
    return $clog2(bytes_per_word);
  endfunction

  localparam int DEFAULT_WORD_SHIFT = word_shift(4);

  // Words written but not yet consumed. An inconsistent read pointer yields a
  // value above size (or an underflowed huge value), which callers treat as full.
  function automatic logic [RING_W:0] ring_fill(
    input logic [RING_W-1:0] wr_off,
    input logic              wr_wrp,
    input logic [RING_W-1:0] rd_off,
    input logic              rd_wrp,
    input logic [RING_W-1:0] ring_size
  );
    if (wr_wrp == rd_wrp) return {1'b0, wr_off} - {1'b0, rd_off};
    else                  return {1'b0, ring_size} - {1'b0, rd_off} + {1'b0, wr_off};
  endfunction

endpackage

// File: rtl/ring_ptr_calc.sv
// Combinational chunk sizing: free space, distance to the ring end and the
// length of the next writer command, plus the decision whether to issue it.
module ring_ptr_calc
  import ring_sched_pkg::*;
#(
  parameter int PTR_W = 20,
  parameter int CNT_W = 12
) (
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic             wr_wrap,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic             rd_wrap,
  input  logic [PTR_W-1:0] size,
  input  logic [PTR_W-1:0] chunk_len,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             flush_pending,
  output logic [PTR_W:0]   free,
  output logic [PTR_W:0]   len,
  output logic             go
);

  localparam int PW = PTR_W + 1;
  localparam int XW = RING_W + 1;
  localparam int CW = (CNT_W > PW) ? CNT_W : PW;

  logic [XW-1:0] fill_x;
  logic [PW-1:0] size_n;
  logic [PW-1:0] to_end;
  logic [PW-1:0] base_len;
  logic [CW-1:0] fifo_c;
  logic [CW-1:0] base_c;
  logic          fifo_short;

  always_comb begin
    size_n   = PW'(size);
    fill_x   = ring_fill(RING_W'(wr_ptr), wr_wrap, RING_W'(rd_ptr), rd_wrap, RING_W'(size));
    free     = (fill_x > XW'(size)) ? '0 : size_n - PW'(fill_x);
    to_end   = size_n - PW'(wr_ptr);
    base_len = PW'(chunk_len);
    if (to_end < base_len) base_len = to_end;
    if (free < base_len)   base_len = free;
    fifo_c     = CW'(fifo_count);
    base_c     = CW'(base_len);
    fifo_short = fifo_c < base_c;
    // A pending flush lets a short FIFO residue go out as a partial chunk.
    len = (flush_pending && fifo_short) ? PW'(fifo_count) : base_len;
    go  = (base_len != '0) && (!fifo_short || (flush_pending && (fifo_count != '0)));
  end

endmodule

// File: rtl/ring_write_scheduler.sv
// Carves a FIFO stream into burst-writer commands landing in a circular
// buffer, tracking the write pointer/wrap bit and throttling on the reader.
module ring_write_scheduler
  import ring_sched_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 32,
  parameter int PTR_W          = 20,
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = 12
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cfg_enable,
  input  logic [ADDR_W-1:0] cfg_ring_base,
  input  logic [PTR_W-1:0]  cfg_ring_size,
  input  logic [PTR_W-1:0]  cfg_chunk_len,
  input  logic              flush,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic              rd_wrap,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic [LEN_W-1:0]  wr_len,
  output logic              wr_start,
  input  logic              wr_busy,
  input  logic              wr_done,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic              wr_wrap,
  output logic              chunk_irq,
  output logic              flush_done,
  output logic              active,
  output logic              stalled_full,
  output state_e            dbg_state
);

  localparam int SHIFT = word_shift(BYTES_PER_WORD);
  localparam int CW    = (CNT_W > PTR_W + 1) ? CNT_W : PTR_W + 1;

  // Writer handshake: wr_start is a single-cycle command strobe issued only
  // with no command outstanding; wr_busy/wr_done from the writer close it out.
  state_e             state, state_d;
  logic               en_q;
  logic [ADDR_W-1:0]  base_q;
  logic [PTR_W-1:0]   size_q;
  logic [PTR_W-1:0]   chunk_q;
  logic [PTR_W:0]     len_q;
  logic               flush_pending;
  logic               flush_done_q;

  logic [PTR_W:0]     free;
  logic [PTR_W:0]     len;
  logic               go;
  logic [PTR_W:0]     ptr_sum;
  logic               load_cfg, take_cmd, flush_clr, flush_fin, stall;

  ring_ptr_calc #(.PTR_W(PTR_W), .CNT_W(CNT_W)) u_calc (
    .wr_ptr        (wr_ptr),
    .wr_wrap       (wr_wrap),
    .rd_ptr        (rd_ptr),
    .rd_wrap       (rd_wrap),
    .size          (size_q),
    .chunk_len     (chunk_q),
    .fifo_count    (fifo_count),
    .flush_pending (flush_pending),
    .free          (free),
    .len           (len),
    .go            (go)
  );

  assign ptr_sum = {1'b0, wr_ptr} + len_q;

  always_comb begin
    state_d   = state;
    load_cfg  = 1'b0;
    take_cmd  = 1'b0;
    flush_clr = 1'b0;
    flush_fin = 1'b0;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        flush_fin = flush;
        if (cfg_enable && !en_q) begin
          load_cfg = 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        // Disable wins over a ready chunk so nothing new starts once it drops.
        if (!cfg_enable && !flush_pending) begin
          state_d = S_IDLE;
        end else if (go) begin
          take_cmd = 1'b1;
          state_d  = S_ISSUE;
        end else if (flush_pending && (fifo_count == '0)) begin
          flush_clr = 1'b1;
          flush_fin = 1'b1;
        end else if ((free == '0) && (fifo_count != '0)) begin
          stall = 1'b1;
        end
      end
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (wr_done)      state_d = S_COMMIT;
        else if (wr_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (wr_done) state_d = S_COMMIT;
      S_COMMIT: begin
        state_d = S_CALC;
        if (flush_pending && (CW'(fifo_count) == CW'(len_q))) begin
          flush_clr = 1'b1;
          flush_fin = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= S_IDLE;
      en_q          <= 1'b0;
      base_q        <= '0;
      size_q        <= '0;
      chunk_q       <= '0;
      len_q         <= '0;
      wr_ptr        <= '0;
      wr_wrap       <= 1'b0;
      wr_base_addr  <= '0;
      wr_len        <= '0;
      flush_pending <= 1'b0;
      flush_done_q  <= 1'b0;
    end else begin
      state        <= state_d;
      en_q         <= cfg_enable;
      flush_done_q <= flush_fin;
      if (flush_clr) flush_pending <= 1'b0;
      if (flush && (state != S_IDLE)) flush_pending <= 1'b1;
      if (load_cfg) begin
        base_q  <= cfg_ring_base;
        size_q  <= cfg_ring_size;
        chunk_q <= cfg_chunk_len;
        wr_ptr  <= '0;
        wr_wrap <= 1'b0;
      end
      if (take_cmd) begin
        len_q        <= len;
        wr_base_addr <= base_q + (ADDR_W'(wr_ptr) << SHIFT);
        wr_len       <= LEN_W'(len);
      end
      if (state == S_COMMIT) begin
        if (ptr_sum == {1'b0, size_q}) begin
          wr_ptr  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_ptr <= ptr_sum[PTR_W-1:0];
        end
      end
    end
  end

  assign wr_start     = (state == S_ISSUE);
  assign chunk_irq    = (state == S_COMMIT);
  assign flush_done   = flush_done_q;
  assign active       = (state != S_IDLE);
  assign stalled_full = stall;
  assign dbg_state    = state;

endmodule

// File: tb/tb_ring_write_scheduler.sv
// Directed bench for ring_write_scheduler: behavioural burst writer with a
// command scoreboard, plus ring wrap, full-stall, flush, disable and reset cases.
module tb_ring_write_scheduler;
  import ring_sched_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;
  localparam int PTR_W  = 20;
  localparam int BPW    = 4;
  localparam int CNT_W  = 12;
  localparam int SEL_START = 0;
  localparam int SEL_IRQ   = 1;
  localparam int SEL_FD    = 2;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              cfg_enable = 1'b0;
  logic [ADDR_W-1:0] cfg_ring_base = '0;
  logic [PTR_W-1:0]  cfg_ring_size = '0;
  logic [PTR_W-1:0]  cfg_chunk_len = '0;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  fifo_count = '0;
  logic [PTR_W-1:0]  rd_ptr = '0;
  logic              rd_wrap = 1'b0;
  logic [ADDR_W-1:0] wr_base_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_start;
  logic              wr_busy = 1'b0;
  logic              wr_done = 1'b0;
  logic [PTR_W-1:0]  wr_ptr;
  logic              wr_wrap;
  logic              chunk_irq;
  logic              flush_done;
  logic              active;
  logic              stalled_full;
  state_e            dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int irq_cnt   = 0;
  int fd_cnt    = 0;
  int busy_len  = 3;
  int busy_left = 0;
  bit fast_mode = 1'b0;
  bit fast_arm  = 1'b0;
  bit follow    = 1'b0;
  logic [63:0] exp_q[$];

  ring_write_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PTR_W(PTR_W), .BYTES_PER_WORD(BPW), .CNT_W(CNT_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cfg_enable(cfg_enable),
    .cfg_ring_base(cfg_ring_base), .cfg_ring_size(cfg_ring_size), .cfg_chunk_len(cfg_chunk_len),
    .flush(flush), .fifo_count(fifo_count), .rd_ptr(rd_ptr), .rd_wrap(rd_wrap),
    .wr_base_addr(wr_base_addr), .wr_len(wr_len), .wr_start(wr_start),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_ptr(wr_ptr), .wr_wrap(wr_wrap),
    .chunk_irq(chunk_irq), .flush_done(flush_done), .active(active),
    .stalled_full(stalled_full), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Writer model and scoreboard, evaluated on the falling edge.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      wr_busy = 1'b0; wr_done = 1'b0; busy_left = 0; fast_arm = 1'b0;
    end else begin
      wr_done = 1'b0;
      if (fast_arm) begin
        wr_done = 1'b1; fast_arm = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin wr_busy = 1'b0; wr_done = 1'b1; end
      end
      if (wr_start) begin
        start_cnt++;
        check("start_while_busy", 64'(wr_busy), 64'd0);
        check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("cmd_addr_len", {wr_base_addr, wr_len}, exp_q.pop_front());
        if (fast_mode) fast_arm = 1'b1;
        else begin wr_busy = 1'b1; busy_left = busy_len; end
      end
      if (chunk_irq)  irq_cnt++;
      if (flush_done) fd_cnt++;
      if (follow) begin rd_ptr = wr_ptr; rd_wrap = wr_wrap; end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(negedge ACLK); #1; end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      SEL_START: return start_cnt;
      SEL_IRQ:   return irq_cnt;
      default:   return fd_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
    int left;
    left = budget;
    while (get_cnt(sel) < target && left > 0) begin tick(1); left--; end
    check(tag, 64'(get_cnt(sel)), 64'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int left;
    left = budget;
    while (active && left > 0) begin tick(1); left--; end
    check(tag, 64'(active), 64'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(1); flush = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] addr, input logic [31:0] len);
    exp_q.push_back({addr, len});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 64'({wr_start, chunk_irq, flush_done, active, stalled_full, wr_wrap}), 64'd0);
    check({tag, "_addr"}, 64'(wr_base_addr), 64'd0);
    check({tag, "_len"}, 64'(wr_len), 64'd0);
    check({tag, "_ptr"}, 64'(wr_ptr), 64'd0);
  endtask

  initial begin
    tick(3);
    check_all_zero("reset");
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    ARESETn = 1'b1;
    tick(2);

    // 1: consumer keeps up; chunk split at ring end and wrap
    cfg_ring_base = 32'h1000; cfg_ring_size = 20'd40; cfg_chunk_len = 20'd16;
    fifo_count = 12'd64; follow = 1'b1;
    push_cmd(32'h1000, 16); push_cmd(32'h1040, 16); push_cmd(32'h1080, 8); push_cmd(32'h1000, 16);
    cfg_enable = 1'b1;
    wait_cnt("t1_three_chunks", SEL_IRQ, 3, 200);
    tick(1);
    check("t1_wrap_ptr", 64'(wr_ptr), 64'd0);
    check("t1_wrap_bit", 64'(wr_wrap), 64'd1);
    wait_cnt("t1_fourth_start", SEL_START, 4, 100);
    cfg_enable = 1'b0;
    wait_cnt("t1_fourth_irq", SEL_IRQ, 4, 100);
    wait_idle("t1_idle", 50);
    check("t1_ptr_after", 64'(wr_ptr), 64'd16);

    // 2: frozen reader, ring fills and stalls until rd_ptr advances
    follow = 1'b0; rd_ptr = '0; rd_wrap = 1'b0;
    push_cmd(32'h1000, 16); push_cmd(32'h1040, 16); push_cmd(32'h1080, 8);
    cfg_enable = 1'b1;
    wait_cnt("t2_fill_ring", SEL_IRQ, 7, 200);
    tick(4);
    check("t2_stalled", 64'(stalled_full), 64'd1);
    check("t2_stall_state", 64'(dbg_state), 64'(S_CALC));
    tick(10);
    check("t2_no_start_when_full", 64'(start_cnt), 64'd7);
    push_cmd(32'h1000, 16);
    rd_ptr = 20'd16;
    wait_cnt("t2_after_free", SEL_IRQ, 8, 100);
    tick(1);
    check("t2_ptr", 64'(wr_ptr), 64'd16);
    check("t2_wrap", 64'(wr_wrap), 64'd1);
    tick(3);
    check("t2_full_again", 64'(stalled_full), 64'd1);
    cfg_enable = 1'b0;
    wait_idle("t2_idle", 20);
    check("t2_stall_clear", 64'(stalled_full), 64'd0);

    // 3: short FIFO waits; flush drains residue; flush with empty FIFO; flush in IDLE
    follow = 1'b1; rd_ptr = '0; rd_wrap = 1'b0; fifo_count = 12'd5;
    cfg_enable = 1'b1;
    tick(10);
    check("t3_no_cmd_short", 64'(start_cnt), 64'd8);
    check("t3_active", 64'(active), 64'd1);
    check("t3_not_stalled", 64'(stalled_full), 64'd0);
    push_cmd(32'h1000, 5);
    pulse_flush();
    wait_cnt("t3_flush_chunk", SEL_IRQ, 9, 50);
    check("t3_fd_not_with_irq", 64'(flush_done), 64'd0);
    tick(1);
    check("t3_fd_after_irq", 64'(flush_done), 64'd1);
    check("t3_ptr", 64'(wr_ptr), 64'd5);
    tick(1);
    check("t3_fd_single", 64'(flush_done), 64'd0);
    fifo_count = '0;
    pulse_flush();
    wait_cnt("t3_empty_flush", SEL_FD, 2, 10);
    check("t3_empty_no_cmd", 64'(start_cnt), 64'd9);
    cfg_enable = 1'b0;
    wait_idle("t3_idle", 20);
    pulse_flush();
    wait_cnt("t3_idle_flush", SEL_FD, 3, 5);

    // 4: disable while the writer is mid-transfer
    fifo_count = 12'd64; busy_len = 10;
    push_cmd(32'h1000, 16);
    cfg_enable = 1'b1;
    wait_cnt("t4_start", SEL_START, 10, 50);
    tick(2);
    check("t4_in_wait_done", 64'(dbg_state), 64'(S_WAIT_DONE));
    cfg_enable = 1'b0;
    wait_cnt("t4_commit", SEL_IRQ, 10, 50);
    tick(1);
    check("t4_ptr", 64'(wr_ptr), 64'd16);
    wait_idle("t4_idle", 20);
    tick(10);
    check("t4_no_more_start", 64'(start_cnt), 64'd10);

    // 5: DONE the cycle after START, BUSY never seen
    fast_mode = 1'b1;
    push_cmd(32'h1000, 16); push_cmd(32'h1040, 16);
    cfg_enable = 1'b1;
    wait_cnt("t5_starts", SEL_START, 12, 100);
    cfg_enable = 1'b0;
    wait_cnt("t5_irqs", SEL_IRQ, 12, 50);
    wait_idle("t5_idle", 20);
    check("t5_start_eq_irq", 64'(start_cnt), 64'(irq_cnt));
    check("t5_ptr", 64'(wr_ptr), 64'd32);

    // 6: asynchronous reset during WAIT_DONE, then restart from base
    fast_mode = 1'b0; busy_len = 10;
    push_cmd(32'h1000, 16); push_cmd(32'h1040, 16);
    cfg_enable = 1'b1;
    wait_cnt("t6_second_start", SEL_START, 14, 100);
    tick(2);
    check("t6_in_wait_done", 64'(dbg_state), 64'(S_WAIT_DONE));
    #2 ARESETn = 1'b0;
    #1;
    check_all_zero("t6_async");
    cfg_enable = 1'b0;
    tick(2);
    ARESETn = 1'b1;
    tick(2);
    check("t6_idle_after_reset", 64'(active), 64'd0);
    push_cmd(32'h1000, 16);
    cfg_enable = 1'b1;
    wait_cnt("t6_restart_irq", SEL_IRQ, 14, 100);
    tick(1);
    check("t6_ptr", 64'(wr_ptr), 64'd16);
    cfg_enable = 1'b0;
    wait_idle("t6_idle", 50);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
